// File: rtl/run_ctrl.sv
// run_ctrl: parks the core, releases it on go, times the run, then streams a data-memory window out
module run_ctrl #(
  parameter int START_CYC = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  input  logic [CNT_W-1:0]  timeout,
  output logic              start,
  input  logic              done,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              fin,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count
);
  localparam int HW = $clog2(START_CYC + 1);
  typedef enum logic [2:0] {IDLE, HOLD, RUN, FETCH, SEND, FIN} state_t;
  state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [CNT_W-1:0] tmo_q, tmo_d, cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] data_q, data_d;
  logic tout_q, tout_d;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    base_d  = base_q;
    addr_d  = addr_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tout_d  = tout_q;
    cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (go) begin
        state_d = HOLD;
        hold_d  = '0;
        base_d  = rd_base;
        len_d   = rd_len;
        tmo_d   = timeout;
        tout_d  = 1'b0;
        cnt_d   = '0;
      end
      HOLD: begin
        hold_d  = hold_q + 1'b1;
        state_d = hold_q == HW'(START_CYC - 1) ? RUN : HOLD;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (done) begin
          state_d = len_q == '0 ? FIN : FETCH;
          addr_d  = base_q;
        end else if (tmo_q != '0 && cnt_inc == tmo_q) begin
          tout_d  = 1'b1;
          state_d = FIN;
        end
      end
      FETCH: begin
        data_d  = mem_rd_data;
        state_d = SEND;
      end
      SEND: if (out_ready) begin
        state_d = len_q == (ADDR_W+1)'(1) ? FIN : FETCH;
        addr_d  = addr_q + 1'b1;
        len_d   = len_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tout_q  <= tout_d;
    end
  end
  assign start       = state_q != RUN;
  assign busy        = state_q != IDLE;
  assign out_valid   = state_q == SEND;
  assign fin         = state_q == FIN;
  assign mem_rd_addr = addr_q;
  assign out_data    = data_q;
  assign timed_out   = tout_q;
  assign cycle_count = cnt_q;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed and random launches of run_ctrl checked against an arithmetic run/readback model
module tb_run_ctrl;
  logic clk, reset, go, start, done, out_valid, out_ready, busy, fin, timed_out;
  logic [7:0] rd_base, mem_rd_addr, mem_rd_data, out_data;
  logic [8:0] rd_len;
  logic [15:0] timeout, cycle_count;
  logic [7:0] mem [256];
  int n_chk = 0;
  int n_fail = 0;
  run_ctrl dut (
    .clk(clk), .reset(reset), .go(go), .rd_base(rd_base), .rd_len(rd_len),
    .timeout(timeout), .start(start), .done(done), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .fin(fin), .timed_out(timed_out),
    .cycle_count(cycle_count)
  );
  assign mem_rd_data = mem[mem_rd_addr];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [7:0] base, input logic [8:0] len, input logic [15:0] tmo,
                     input int dn, input int mode, input bit gorun);
    bit dpath;
    int run_len, words, idx, stall;
    bit got_fin, rdy;
    logic [7:0] ea;
    dpath   = dn != 0 && (tmo == 0 || dn <= int'(tmo));
    run_len = dpath ? dn : int'(tmo);
    words   = dpath ? int'(len) : 0;
    chk("idle_busy", busy, 1'b0);
    chk("idle_start", start, 1'b1);
    go = 1'b1; rd_base = base; rd_len = len; timeout = tmo;
    @(negedge clk);
    go = 1'b0; rd_base = 8'($urandom); rd_len = 9'($urandom); timeout = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk("hold_start", start, 1'b1);
      chk("hold_busy", busy, 1'b1);
      if (i == 0) begin
        chk("go_clr_to", timed_out, 1'b0);
        chk("go_clr_cnt", cycle_count, 16'd0);
      end
      @(negedge clk);
    end
    for (int k = 1; k <= run_len; k++) begin
      chk("run_start", start, 1'b0);
      done = dpath && k == dn;
      go = gorun && k == 2;
      @(negedge clk);
    end
    done = 1'b0; go = 1'b0;
    chk("post_run_start", start, 1'b1);
    chk("cycle_count", cycle_count, run_len);
    chk("timed_out", timed_out, !dpath);
    idx = 0; stall = 4; got_fin = 1'b0;
    for (int c = 0; c < 3000 && !got_fin; c++) begin
      if (fin) begin
        got_fin = 1'b1;
        chk("word_count", idx, words);
        if (mode == 0) chk("fin_cycle", c, 2 * words);
      end else begin
        chk("rb_start", start, 1'b1);
        if (out_valid) begin
          ea = base + idx[7:0];
          chk("out_data", out_data, mem[ea]);
          chk("rd_addr", mem_rd_addr, ea);
        end
        rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom) : !(idx == 1 && stall > 0);
        if (mode == 2 && idx == 1 && out_valid && stall > 0) stall--;
        if (out_valid && rdy) idx++;
        out_ready = rdy;
        done = 1'($urandom);
        @(negedge clk);
      end
    end
    chk("fin_seen", got_fin, 1'b1);
    out_ready = 1'b0; done = 1'b0;
    @(negedge clk);
    chk("fin_pulse", fin, 1'b0);
    chk("hold_to", timed_out, !dpath);
    chk("hold_cnt", cycle_count, run_len);
    repeat (2) begin
      @(negedge clk);
      chk("stay_idle", busy, 1'b0);
    end
  endtask
  initial begin
    int dn, tm;
    reset = 1'b0; go = 1'b0; done = 1'b0; out_ready = 1'b0;
    rd_base = '0; rd_len = '0; timeout = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C; mem[8'h12] = 8'hFF;
    mem[8'h20] = 8'h77;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("rst_start", start, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_addr", mem_rd_addr, 8'h00);
    chk("rst_fin", fin, 1'b0);
    chk("rst_to", timed_out, 1'b0);
    chk("rst_cnt", cycle_count, 16'd0);
    run(8'h10, 9'd3, 16'd0, 10, 0, 1'b0);
    run(8'h40, 9'd3, 16'd5, 0, 0, 1'b0);
    run(8'h10, 9'd3, 16'd0, 10, 2, 1'b0);
    run(8'hFE, 9'd4, 16'd0, 6, 1, 1'b0);
    run(8'h33, 9'd0, 16'd7, 7, 0, 1'b0);
    run(8'h50, 9'd2, 16'd0, 5, 0, 1'b1);
    go = 1'b1; rd_base = 8'h20; rd_len = 9'd5; timeout = 16'd0;
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_data", out_data, 8'h77);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst_start", start, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_addr", mem_rd_addr, 8'h00);
    chk("mid_rst_fin", fin, 1'b0);
    chk("mid_rst_cnt", cycle_count, 16'd0);
    for (int t = 0; t < 12; t++) begin
      dn = $urandom_range(20, 0);
      tm = $urandom_range(20, 0);
      if (dn == 0 && tm == 0) dn = 5;
      run(8'($urandom), 9'($urandom_range(6, 0)), 16'(tm), dn, $urandom_range(1, 0), 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
